// File: rtl/move_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : move_ctrl_pkg
//  Description : Shared types and constants for the tic-tac-toe move
//                controller: FSM state encoding, board size and the table
//                of the eight winning lines.
//  Revision    : 1.0 - initial release
// ============================================================================
package move_ctrl_pkg;

    // Number of cells on the 3x3 board, row-major 0..8
    localparam int NUM_CELLS = 9;
    // Number of candidate winning lines (3 rows, 3 columns, 2 diagonals)
    localparam int NUM_LINES = 8;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_APPLY = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    // Cell indices of each line: rows, then columns, then the two diagonals
    localparam logic [3:0] LINE_TABLE [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Expand one line of the table into a nine-bit cell mask
    function automatic logic [NUM_CELLS-1:0] line_mask(input logic [2:0] line);
        logic [NUM_CELLS-1:0] m;
        m = '0;
        for (int j = 0; j < 3; j++) begin
            m = m | ({{(NUM_CELLS-1){1'b0}}, 1'b1} << LINE_TABLE[line][j]);
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/move_ctrl_line_check.sv
`default_nettype none
// ============================================================================
//  Module      : line_check
//  Description : Combinational evaluation of one board line. A line is hit
//                when all three of its cells are occupied and every stored
//                symbol matches the requested symbol.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_check
    import move_ctrl_pkg::*;
(
    input  logic [2:0]           line_idx,
    input  logic [NUM_CELLS-1:0] cell_valid,
    input  logic [NUM_CELLS-1:0] cell_symbol,
    input  logic                 symbol,
    output logic                 hit
);

    logic [NUM_CELLS-1:0] w_mask;
    logic                 w_all_valid;
    logic                 w_all_match;

    // Mask out the three cells of the selected line and test them together
    always_comb begin
        w_mask      = line_mask(line_idx);
        w_all_valid = ((cell_valid & w_mask) == w_mask);
        w_all_match = (((cell_symbol ^ {NUM_CELLS{symbol}}) & w_mask) == '0);
        hit         = w_all_valid && w_all_match;
    end

endmodule
`default_nettype wire

// File: rtl/move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : move_ctrl
//  Description : Move controller for a 3x3 board held in external cells.
//                Accepts a move in IDLE, writes it in APPLY, scans the eight
//                lines over eight CHECK cycles, then either hands the turn
//                over, or reports a win/draw and waits in DONE for new_game.
//  Revision    : 1.0 - initial release
// ============================================================================
module move_ctrl
    import move_ctrl_pkg::*;
#(
    parameter logic FIRST_SYMBOL = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_game,
    input  logic                 move_valid,
    input  logic [3:0]           move_idx,
    output logic                 move_ready,
    output logic                 move_err,
    input  logic [NUM_CELLS-1:0] cell_valid,
    input  logic [NUM_CELLS-1:0] cell_symbol,
    output logic [NUM_CELLS-1:0] cell_set,
    output logic                 cell_set_symbol,
    output logic                 cell_reset,
    output logic                 turn,
    output logic                 game_over,
    output logic                 win,
    output logic                 draw,
    output logic                 winner
);

    state_t               r_state;
    logic [2:0]           r_line;
    logic                 r_hit;
    logic                 r_sym;
    logic                 r_turn;
    logic                 r_move_ready;
    logic                 r_move_err;
    logic [NUM_CELLS-1:0] r_cell_set;
    logic                 r_cell_reset;
    logic                 r_game_over;
    logic                 r_win;
    logic                 r_draw;
    logic                 r_winner;

    logic [NUM_CELLS-1:0] w_req_onehot;
    logic                 w_illegal;
    logic                 w_line_hit;
    logic                 w_accept;

    // Decode the requested cell and judge legality; indices above 8 shift
    // the one-hot out of range and are rejected explicitly
    always_comb begin
        w_req_onehot = {{(NUM_CELLS-1){1'b0}}, 1'b1} << move_idx;
        w_illegal    = (move_idx > 4'd8) || ((cell_valid & w_req_onehot) != '0);
        w_accept     = move_valid && r_move_ready;
    end

    // Line evaluator, stepped through lines 0..7 by r_line during CHECK
    line_check u_line_check (
        .line_idx    (r_line),
        .cell_valid  (cell_valid),
        .cell_symbol (cell_symbol),
        .symbol      (r_sym),
        .hit         (w_line_hit)
    );

    // Controller FSM with all outputs registered.
    // move_ready is cleared on acceptance and only re-armed after one full
    // cycle back in IDLE, which gives the return cycle after CHECK; leaving
    // CLEAR arms it directly so a fresh game is ready immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_CLEAR;
            r_line       <= 3'd0;
            r_hit        <= 1'b0;
            r_sym        <= FIRST_SYMBOL;
            r_turn       <= FIRST_SYMBOL;
            r_move_ready <= 1'b0;
            r_move_err   <= 1'b0;
            r_cell_set   <= '0;
            r_cell_reset <= 1'b1;
            r_game_over  <= 1'b0;
            r_win        <= 1'b0;
            r_draw       <= 1'b0;
            r_winner     <= 1'b0;
        end else begin
            r_move_err   <= 1'b0;
            r_cell_set   <= '0;
            r_cell_reset <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_move_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_illegal) begin
                            r_move_err <= 1'b1;
                        end else begin
                            r_sym        <= r_turn;
                            r_cell_set   <= w_req_onehot;
                            r_move_ready <= 1'b0;
                            r_state      <= ST_APPLY;
                        end
                    end
                end
                ST_APPLY: begin
                    r_line  <= 3'd0;
                    r_hit   <= 1'b0;
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    r_hit  <= r_hit | w_line_hit;
                    r_line <= r_line + 3'd1;
                    if (r_line == 3'd7) begin
                        if (r_hit || w_line_hit) begin
                            r_game_over <= 1'b1;
                            r_win       <= 1'b1;
                            r_draw      <= 1'b0;
                            r_winner    <= r_sym;
                            r_state     <= ST_DONE;
                        end else if (&cell_valid) begin
                            r_game_over <= 1'b1;
                            r_win       <= 1'b0;
                            r_draw      <= 1'b1;
                            r_winner    <= 1'b0;
                            r_state     <= ST_DONE;
                        end else begin
                            r_turn  <= ~r_turn;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (new_game) begin
                        r_cell_reset <= 1'b1;
                        r_state      <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_game_over  <= 1'b0;
                    r_win        <= 1'b0;
                    r_draw       <= 1'b0;
                    r_winner     <= 1'b0;
                    r_turn       <= FIRST_SYMBOL;
                    r_move_ready <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_cell_reset <= 1'b1;
                    r_move_ready <= 1'b0;
                    r_state      <= ST_CLEAR;
                end
            endcase
        end
    end

    assign move_ready      = r_move_ready;
    assign move_err        = r_move_err;
    assign cell_set        = r_cell_set;
    assign cell_set_symbol = r_sym;
    assign cell_reset      = r_cell_reset;
    assign turn            = r_turn;
    assign game_over       = r_game_over;
    assign win             = r_win;
    assign draw            = r_draw;
    assign winner          = r_winner;

endmodule
`default_nettype wire
